// File: rtl/spi_pkg.sv
// Constants and state encoding shared by the SPI master and slave nodes
// of the interconnect memory link.
package spi_pkg;

  localparam int ADDR_BITS  = 8;
  localparam int INSTR_BITS = 32;
  localparam int FRAME_BITS = ADDR_BITS + INSTR_BITS;
  localparam logic [ADDR_BITS-1:0] BROADCAST_ADDR = 8'hFF;

  // The bit counter saturates one past a full frame so an overlong frame is
  // still distinguishable from an exact one.
  localparam int CNT_BITS = 6;
  localparam logic [CNT_BITS-1:0] CNT_ADDR_LAST = CNT_BITS'(ADDR_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_FRAME     = CNT_BITS'(FRAME_BITS);
  localparam logic [CNT_BITS-1:0] CNT_SAT       = CNT_BITS'(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    INSTR,
    SKIP,
    ERROR
  } spi_slave_state_t;

endpackage

// File: rtl/slave_spi_node_if.sv
// SPI pins plus the instruction-side outputs of a slave node.
interface slave_spi_node_if import spi_pkg::*; ();

  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_en;
  logic [INSTR_BITS-1:0] out_instr;
  logic                  check;
  logic                  err;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, miso_en, out_instr, check, err
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, miso_en, out_instr, check, err
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Clearing to 0 means a cs_n held low through reset never yields a fall,
  // so a frame interrupted by reset cannot be resumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what turns this into a real shift chain.
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise =  q & ~prev;
  assign fall = ~q &  prev;

endmodule

// File: rtl/slave_spi_node.sv
// SPI slave endpoint: receives {addr, instr} frames, latches instructions
// addressed to this node and shifts the previous instruction back on MISO.
module slave_spi_node import spi_pkg::*; #(
  parameter logic [ADDR_BITS-1:0] NODE_ADDR   = 8'h00,
  parameter int                   SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             reset,
  slave_spi_node_if.slave bus
);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(bus.sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .reset(reset), .d(bus.cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  // Same depth as sclk so the data bit lines up with its sampling edge.
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk(clk), .reset(reset), .d(bus.mosi),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_slave_state_t      state;
  logic [CNT_BITS-1:0]   bit_cnt;
  logic [FRAME_BITS-1:0] rx_sr;
  logic [INSTR_BITS-1:0] tx_sr;
  logic [ADDR_BITS-1:0]  rx_addr;
  logic                  unused_ok;

  assign rx_addr   = {rx_sr[ADDR_BITS-2:0], mosi_q};
  assign unused_ok = ^{sclk_q, cs_rise, mosi_rise, mosi_fall, rx_sr[FRAME_BITS-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      bus.out_instr <= '0;
      bus.check     <= 1'b0;
      bus.err       <= 1'b0;
      bus.miso      <= 1'b0;
      bus.miso_en   <= 1'b0;
    end else begin
      bus.check <= 1'b0;
      bus.err   <= 1'b0;

      if (state != IDLE && sclk_rise && bit_cnt != CNT_SAT)
        bit_cnt <= bit_cnt + 6'd1;

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ADDR;
            bit_cnt <= '0;
            rx_sr   <= '0;
          end
        end

        ADDR: begin
          if (cs_q) begin
            state   <= IDLE;
            bus.err <= 1'b1;
          end else if (sclk_rise) begin
            rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_q};
            if (bit_cnt == CNT_ADDR_LAST) begin
              if (rx_addr == NODE_ADDR || rx_addr == BROADCAST_ADDR) begin
                state       <= INSTR;
                bus.miso_en <= 1'b1;
                tx_sr       <= bus.out_instr;
              end else begin
                state <= SKIP;
              end
            end
          end
        end

        INSTR: begin
          if (cs_q) begin
            state       <= IDLE;
            bus.miso_en <= 1'b0;
            bus.miso    <= 1'b0;
            if (bit_cnt == CNT_FRAME) begin
              bus.out_instr <= rx_sr[INSTR_BITS-1:0];
              bus.check     <= 1'b1;
            end else begin
              bus.err <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (bit_cnt == CNT_FRAME) begin
              state       <= ERROR;
              bus.err     <= 1'b1;
              bus.miso_en <= 1'b0;
              bus.miso    <= 1'b0;
            end else begin
              rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_q};
            end
          end else if (sclk_fall) begin
            bus.miso <= tx_sr[INSTR_BITS-1];
            tx_sr    <= {tx_sr[INSTR_BITS-2:0], 1'b0};
          end
        end

        SKIP, ERROR: begin
          if (cs_q) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_spi_node.sv
// Randomised bench for slave_spi_node: a bit-banged SPI master, a
// frame-level reference model and a pulse scoreboard.
module tb_slave_spi_node;
  import spi_pkg::*;

  localparam logic [7:0] NODE = 8'h00;
  localparam int         SYNC = 2;
  localparam int         HALF = 6;

  typedef struct {
    bit          is_err;
    logic [31:0] instr;
    longint      ref_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  exp_t   exp_q[$];
  logic [31:0] model_instr = '0;

  slave_spi_node_if bus ();

  slave_spi_node #(.NODE_ADDR(NODE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(input bit is_err, input logic [31:0] instr);
    exp_t e;
    e.is_err  = is_err;
    e.instr   = instr;
    e.ref_cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every check/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (bus.check || bus.err)) begin
      check("check_err_exclusive", 40'(bus.check & bus.err), 40'd0);
      check("pulse_expected", 40'(exp_q.size() > 0), 40'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", 40'({bus.check, bus.err}), e.is_err ? 40'b01 : 40'b10);
        check("pulse_latency", 40'(cyc - e.ref_cyc), 40'(SYNC + 1));
        check("out_instr_at_pulse", 40'(bus.out_instr), 40'(e.instr));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model_instr = '0;
    check("rst_out_instr", 40'(bus.out_instr), 40'd0);
    check("rst_miso_en", 40'(bus.miso_en), 40'd0);
    check("rst_miso", 40'(bus.miso), 40'd0);
    check("rst_check", 40'(bus.check), 40'd0);
    check("rst_err", 40'(bus.err), 40'd0);
  endtask

  // Drives one frame of nbits sclk pulses; reset_after > 0 pulses reset
  // right after that many rising edges.
  task automatic frame(input logic [7:0] addr, input logic [31:0] instr,
                       input int nbits, input int reset_after);
    logic [39:0] data;
    logic [31:0] rb;
    logic [31:0] prev;
    bit          match;
    bit          aborted;
    bit          exp_en;
    int          en_bad;
    data    = {addr, instr};
    match   = (addr == NODE) || (addr == 8'hFF);
    aborted = 1'b0;
    en_bad  = 0;
    rb      = '0;
    prev    = model_instr;

    @(negedge clk);
    bus.cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.mosi = (i < 40) ? data[39-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 40) begin
        exp_en = match && (i >= 8) && !aborted;
        if (bus.miso_en !== exp_en) en_bad++;
        if (i >= 8) rb[39-i] = bus.miso;
      end
      bus.sclk = 1'b1;
      if (i == 40 && match && !aborted) push(1'b1, model_instr);
      if (i + 1 == reset_after) begin
        do_reset();
        aborted = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    bus.cs_n = 1'b1;

    if (!aborted && nbits <= 40) begin
      if (nbits < 8) push(1'b1, model_instr);
      else if (match) begin
        if (nbits == 40) begin
          model_instr = instr;
          push(1'b0, instr);
        end else begin
          push(1'b1, model_instr);
        end
      end
    end

    check("miso_en_pattern", 40'(en_bad), 40'd0);
    if (match && nbits >= 40 && !aborted) check("miso_readback", 40'(rb), 40'(prev));

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("pulse_arrived", 40'(exp_q.size()), 40'd0);
    repeat (HALF) @(negedge clk);
    check("out_instr_hold", 40'(bus.out_instr), 40'(model_instr));
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  a;
    logic [31:0] ins;
    int          nb;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    repeat (4) @(negedge clk);
    do_reset();
    repeat (8) @(negedge clk);

    frame(8'h00, 32'd50000, 40, 0);
    frame(8'h05, 32'd10000, 40, 0);
    frame(8'h00, 32'd10000, 40, 0);
    frame(8'hFF, 32'd7, 40, 0);
    frame(8'h00, $urandom, 20, 0);
    frame(8'h00, $urandom, 41, 0);
    frame(8'h00, $urandom, 5, 0);
    frame(8'h00, $urandom, 40, 15);
    frame(8'h00, 32'd123, 40, 0);

    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 8'h00;
        1:       a = 8'hFF;
        default: a = 8'($urandom_range(1, 254));
      endcase
      ins = $urandom;
      case ($urandom_range(0, 5))
        0:       nb = $urandom_range(1, 39);
        1:       nb = 41;
        default: nb = 40;
      endcase
      frame(a, ins, nb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_spi_node.md
# slave_spi_node

SPI slave endpoint for the interconnect network, on the receiving end of the SPI master memory link. Deserialises 40-bit frames (8-bit address, then 32-bit instruction) from the master. On an address match it latches the instruction and raises `check` for one cycle. While clocking in a frame, it shifts its previously latched instruction back on MISO for readback.

## Interface
Parameters:
- `NODE_ADDR`, default 8'h00: address this node answers to; 8'hFF (broadcast) is always accepted.
- `SYNC_STAGES`, default 2: synchroniser depth for `sclk`, `cs_n`, `mosi`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from master, asynchronous to `clk`; mode 0 (idle low).
- `cs_n`  in  1  active-low chip select from master.
- `mosi`  in  1  serial data from master, MSB first.
- `miso`  out  1  serial readback data, MSB first.
- `miso_en`  out  1  MISO drive enable (external tristate control).
- `out_instr`  out  32  last accepted instruction.
- `check`  out  1  one-cycle pulse: `out_instr` updated.
- `err`  out  1  one-cycle pulse: malformed frame discarded.

## Operation
- Reset values: `out_instr`=0, `check`=0, `err`=0, `miso`=0, `miso_en`=0, state IDLE, bit counter 0.
- `sclk`, `cs_n` and `mosi` pass through the `SYNC_STAGES` flops. Rising and falling edges of `sclk` and `cs_n` are detected in the `clk` domain.
- Sampling and shifting:
  - Sample `mosi` on a synchronised `sclk` rising edge.
  - Update `miso` on a `sclk` falling edge.
- States:
  - IDLE: `cs_n` falls → ADDR; bit counter cleared; shift register cleared.
  - ADDR: shift 8 bits. At the 8th bit:
    - Address equals `NODE_ADDR` or 8'hFF → INSTR; `miso_en`=1; MISO source loaded from `out_instr`.
    - Otherwise → SKIP.
  - INSTR: shift 32 bits.
    - `miso` presents `out_instr[31]` after the 8th falling edge, then one bit per falling edge.
    - 41st rising edge while `cs_n` is low → ERROR.
  - SKIP: ignore data; `miso_en`=0; `cs_n` rises → IDLE with no pulse.
  - ERROR: `miso_en`=0; wait for `cs_n` high → IDLE.
- `cs_n` rises in INSTR:
  - Exactly 32 instruction bits received → `out_instr` ← shift register; `check`=1 for one cycle; → IDLE.
  - Fewer than 32 bits → `err`=1 for one cycle; `out_instr` unchanged; → IDLE.
- `cs_n` rises in ADDR (short frame) → `err` pulse; → IDLE.
- Entering ERROR pulses `err` once; `out_instr` unchanged.
- `miso_en` drops in the same cycle that `cs_n` is seen high.
- Bit counter is 6 bits wide and saturates at 41; no wrap.
- Reset mid-frame:
  - All state returns to reset values.
  - If `cs_n` is still low after `reset` deasserts, the block stays in IDLE and waits for a fresh `cs_n` fall. The partial frame is never accepted.
- `check` and `err` are never high in the same cycle.

## Timing
- Constraints on the master:
  - `sclk` high and low phases each ≥ `SYNC_STAGES`+2 `clk` periods.
  - `cs_n` setup to first `sclk` rise ≥ `SYNC_STAGES`+2 `clk` periods.
- Latency, `cs_n` pin rise → `check`/`err` high = `SYNC_STAGES`+1 `clk` cycles (3 at default).
- `out_instr` changes in the same cycle `check` rises, then holds until the next accepted frame.
- `miso` is valid ≤ `SYNC_STAGES`+1 `clk` cycles after each `sclk` pin falling edge; the master samples it on the next `sclk` rise.
- Back-to-back frames need `cs_n` high for ≥ `SYNC_STAGES`+2 `clk` cycles.

## Structure
- Package `spi_pkg`:
  - `ADDR_BITS`=8, `INSTR_BITS`=32, `FRAME_BITS`=40, `BROADCAST_ADDR`=8'hFF.
  - State enum `spi_slave_state_t` {IDLE, ADDR, INSTR, SKIP, ERROR}.
  - Shared with the master.
- Sub-module `spi_sync_edge`: parameterised-depth synchroniser plus rise/fall pulse outputs. Instantiated for `sclk` and `cs_n`; `mosi` uses the synchroniser only.
- Top level: FSM, 6-bit bit counter, 40-bit receive shift register, 32-bit MISO shift register.

## Test plan
- Reset, then frame addr 8'h00, instr 32'd50000 → exactly one `check` pulse 3 cycles after `cs_n` rise; `out_instr`=50000; `err` stays 0.
- Frame addr 8'h05, instr 32'd10000 → no `check`, no `err`; `out_instr` stays 50000; `miso_en` low throughout.
- Frame addr 8'h00, instr 32'd10000 → MISO returns 32'd50000 MSB first over the instruction phase; afterwards `out_instr`=10000; broadcast 8'hFF with 32'd7 → `out_instr`=7.
- `cs_n` raised after 20 bits, then separately after 41 bits → one `err` pulse each, no `check`; `out_instr` unchanged.
- `reset` pulsed after bit 15 with `cs_n` held low → outputs 0, rest of frame ignored; next full frame addr 8'h00, 32'd123 → `check` pulse, `out_instr`=123.
